// File: rtl/md_byte_realigner_if.sv
// MD RX/TX handshake bundle for md_byte_realigner.
// The master side drives RX beats and accepts TX words; the slave side is the realigner.
interface md_byte_realigner_if #(
  parameter int ALGN_DATA_WIDTH = 32
);
  localparam int BYTES_W = ALGN_DATA_WIDTH / 8;
  localparam int OW      = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES_W);
  localparam int SW      = $clog2(BYTES_W) + 1;

  logic                       md_rx_valid;
  logic [ALGN_DATA_WIDTH-1:0] md_rx_data;
  logic [OW-1:0]              md_rx_offset;
  logic [SW-1:0]              md_rx_size;
  logic                       md_rx_ready;
  logic                       md_rx_err;
  logic                       md_tx_valid;
  logic [ALGN_DATA_WIDTH-1:0] md_tx_data;
  logic [OW-1:0]              md_tx_offset;
  logic [SW-1:0]              md_tx_size;
  logic                       md_tx_ready;

  modport master (
    output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, md_tx_ready,
    input  md_rx_ready, md_rx_err, md_tx_valid, md_tx_data, md_tx_offset, md_tx_size
  );

  modport slave (
    input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, md_tx_ready,
    output md_rx_ready, md_rx_err, md_tx_valid, md_tx_data, md_tx_offset, md_tx_size
  );
endinterface

// File: rtl/md_byte_realigner.sv
// Byte realigner: packs valid RX byte windows into a circular buffer and emits TX words at a configured lane.
// Optional MD_REALIGN_DROP_CNT_EN adds a saturating cnt_drop counter of discarded RX beats.
module md_byte_realigner #(
  parameter  int ALGN_DATA_WIDTH = 32,
  parameter  int BUF_DEPTH_BYTES = 16,
  localparam int BYTES_W         = ALGN_DATA_WIDTH / 8,
  localparam int OW              = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES_W),
  localparam int SW              = $clog2(BYTES_W) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  md_byte_realigner_if.slave  md,
  input  logic [OW-1:0]       ctrl_offset,
  input  logic [SW-1:0]       ctrl_size
`ifdef MD_REALIGN_DROP_CNT_EN
  ,
  output logic [7:0]          cnt_drop
`endif
);
  localparam int PW = $clog2(BUF_DEPTH_BYTES);
  localparam int CW = $clog2(BUF_DEPTH_BYTES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 mem_q [BUF_DEPTH_BYTES];
  logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       rx_ready_q, rx_err_q;
  logic                       tx_valid_q, tx_valid_d;
  logic [ALGN_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [OW-1:0]              tx_off_q, lat_off_q;
  logic [SW-1:0]              tx_size_q, lat_size_q;
  logic                       rx_fire, rx_ok, ctrl_ok, latch_en, load_en;
  logic [SW-1:0]              push, pop;

  function automatic logic beat_valid(input logic [OW-1:0] o, input logic [SW-1:0] s);
    int oi, si;
    oi = int'(o);
    si = int'(s);
    if (si == 0 || si > BYTES_W || oi >= BYTES_W) return 1'b0;
    return ((BYTES_W + oi) % si) == 0;
  endfunction

  // RX side: accept, validate, size the push
  assign rx_fire = md.md_rx_valid & rx_ready_q;
  assign rx_ok   = beat_valid(md.md_rx_offset, md.md_rx_size);
  assign push    = (rx_fire && rx_ok) ? md.md_rx_size : '0;

  // A ctrl whose window spills past the top lane is rejected like any other invalid ctrl
  assign ctrl_ok = beat_valid(ctrl_offset, ctrl_size)
                && ((int'(ctrl_offset) + int'(ctrl_size)) <= BYTES_W)
                && (cnt_q >= CW'(ctrl_size));

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // TX FSM: next state and pop control
  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    load_en    = 1'b0;
    tx_valid_d = tx_valid_q;
    pop        = '0;
    case (state_q)
      IDLE: begin
        if (ctrl_ok) begin
          latch_en = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        pop        = lat_size_q;
        tx_valid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (md.md_tx_ready) begin
          tx_valid_d = 1'b0;
          if (ctrl_ok) begin
            latch_en = 1'b1;
            state_d  = LOAD;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX word assembly from the oldest buffered bytes
  always_comb begin
    tx_data_d = '0;
    for (int i = 0; i < BYTES_W; i++) begin
      if (i < int'(lat_size_q))
        tx_data_d[8*((int'(lat_off_q) + i) % BYTES_W) +: 8] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

  // Register stage: control state and outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      rx_ready_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_off_q   <= '0;
      tx_size_q  <= '0;
      lat_off_q  <= '0;
      lat_size_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_q + PW'(pop);
      wr_ptr_q   <= wr_ptr_q + PW'(push);
      cnt_q      <= cnt_d;
      rx_ready_q <= (CW'(BUF_DEPTH_BYTES) - cnt_d) >= CW'(BYTES_W);
      rx_err_q   <= rx_fire & ~rx_ok;
      tx_valid_q <= tx_valid_d;
      if (latch_en) begin
        lat_off_q  <= ctrl_offset;
        lat_size_q <= ctrl_size;
      end
      if (load_en) begin
        tx_data_q <= tx_data_d;
        tx_off_q  <= lat_off_q;
        tx_size_q <= lat_size_q;
      end
    end
  end

  // Buffer storage; lanes past the top of the bus wrap around to lane 0
  always_ff @(posedge clk) begin
    if (reset_n && rx_fire && rx_ok) begin
      for (int i = 0; i < BYTES_W; i++) begin
        if (i < int'(md.md_rx_size))
          mem_q[wr_ptr_q + PW'(i)] <= md.md_rx_data[8*((int'(md.md_rx_offset) + i) % BYTES_W) +: 8];
      end
    end
  end

`ifdef MD_REALIGN_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      drop_q <= '0;
    else if (rx_err_q && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  assign cnt_drop = drop_q;
`endif

  assign md.md_rx_ready  = rx_ready_q;
  assign md.md_rx_err    = rx_err_q;
  assign md.md_tx_valid  = tx_valid_q;
  assign md.md_tx_data   = tx_data_q;
  assign md.md_tx_offset = tx_off_q;
  assign md.md_tx_size   = tx_size_q;
endmodule

// File: tb/tb_md_byte_realigner.sv
// Directed testbench for md_byte_realigner (32-bit bus, 16-byte buffer).
module tb_md_byte_realigner;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] ctrl_offset;
  logic [2:0] ctrl_size;
`ifdef MD_REALIGN_DROP_CNT_EN
  logic [7:0] cnt_drop;
`endif

  int checks = 0;
  int errors = 0;
  logic rdy;

  md_byte_realigner_if #(.ALGN_DATA_WIDTH(32)) md_if ();

  md_byte_realigner #(.ALGN_DATA_WIDTH(32), .BUF_DEPTH_BYTES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .md          (md_if),
    .ctrl_offset (ctrl_offset),
    .ctrl_size   (ctrl_size)
`ifdef MD_REALIGN_DROP_CNT_EN
    ,
    .cnt_drop    (cnt_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input string tag, input logic [1:0] o, input logic [2:0] s,
                           input logic [31:0] d);
    int n;
    md_if.md_rx_valid  = 1'b1;
    md_if.md_rx_offset = o;
    md_if.md_rx_size   = s;
    md_if.md_rx_data   = d;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin
      rdy = md_if.md_rx_ready;
      cyc();
      n++;
    end
    md_if.md_rx_valid = 1'b0;
    chk(tag, 32'(rdy), 32'd1);
  endtask

  task automatic wait_tx(input string tag);
    int n;
    n = 0;
    while (md_if.md_tx_valid !== 1'b1 && n < 12) begin
      cyc();
      n++;
    end
    chk(tag, 32'(md_if.md_tx_valid), 32'd1);
  endtask

  task automatic tx_accept();
    md_if.md_tx_ready = 1'b1;
    cyc();
    md_if.md_tx_ready = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    md_if.md_rx_valid  = 1'b0;
    md_if.md_rx_data   = '0;
    md_if.md_rx_offset = '0;
    md_if.md_rx_size   = '0;
    md_if.md_tx_ready  = 1'b0;
    ctrl_offset        = 2'd0;
    ctrl_size          = 3'd4;
    cyc();
    cyc();
    chk("rst_rx_ready", 32'(md_if.md_rx_ready), 32'd0);
    chk("rst_rx_err",   32'(md_if.md_rx_err),   32'd0);
    chk("rst_tx_valid", 32'(md_if.md_tx_valid), 32'd0);
    chk("rst_tx_data",  md_if.md_tx_data,       32'd0);
    reset_n = 1'b1;
    cyc();
    chk("rel_rx_ready", 32'(md_if.md_rx_ready), 32'd1);

    // Full-word pass-through and first-word latency
    send_beat("t1_acc", 2'd0, 3'd4, 32'hDDCCBBAA);
    chk("t1_lat_n1", 32'(md_if.md_tx_valid), 32'd0);
    cyc();
    chk("t1_lat_n1b", 32'(md_if.md_tx_valid), 32'd0);
    cyc();
    chk("t1_lat_n2", 32'(md_if.md_tx_valid), 32'd1);
    chk("t1_data", md_if.md_tx_data, 32'hDDCCBBAA);
    chk("t1_off",  32'(md_if.md_tx_offset), 32'd0);
    chk("t1_size", 32'(md_if.md_tx_size), 32'd4);
    tx_accept();
    chk("t1_done", 32'(md_if.md_tx_valid), 32'd0);

    // Partial beats repacked at lane 2
    ctrl_offset = 2'd2;
    ctrl_size   = 3'd2;
    send_beat("t2_acc1", 2'd1, 3'd1, 32'h0000AA00);
    send_beat("t2_acc2", 2'd2, 3'd2, 32'hBBCC0000);
    wait_tx("t2_wait");
    chk("t2_data", md_if.md_tx_data, 32'hCCAA0000);
    chk("t2_off",  32'(md_if.md_tx_offset), 32'd2);
    chk("t2_size", 32'(md_if.md_tx_size), 32'd2);
    tx_accept();
    chk("t2_idle", 32'(md_if.md_tx_valid), 32'd0);
    ctrl_offset = 2'd3;
    ctrl_size   = 3'd1;
    wait_tx("t2_wait_rem");
    chk("t2_rem_data", md_if.md_tx_data, 32'hBB000000);
    chk("t2_rem_off",  32'(md_if.md_tx_offset), 32'd3);
    tx_accept();

    // Invalid RX beat is dropped with a one-cycle error pulse; invalid ctrl holds TX off
    ctrl_offset = 2'd3;
    ctrl_size   = 3'd2;
    send_beat("t3_acc", 2'd1, 3'd2, 32'h99887766);
    chk("t3_err_pulse", 32'(md_if.md_rx_err), 32'd1);
    cyc();
    chk("t3_err_clear", 32'(md_if.md_rx_err), 32'd0);
`ifdef MD_REALIGN_DROP_CNT_EN
    chk("t3_cnt_drop", 32'(cnt_drop), 32'd1);
`endif
    send_beat("t4_acc1", 2'd0, 3'd4, 32'h44332211);
    send_beat("t4_acc2", 2'd0, 3'd4, 32'h88776655);
    cyc();
    cyc();
    cyc();
    chk("t4_no_tx", 32'(md_if.md_tx_valid), 32'd0);
    ctrl_offset = 2'd0;
    ctrl_size   = 3'd4;
    wait_tx("t4_wait1");
    chk("t4_word1", md_if.md_tx_data, 32'h44332211);
    tx_accept();
    wait_tx("t4_wait2");
    chk("t4_word2", md_if.md_tx_data, 32'h88776655);
    tx_accept();

    // Back-pressure: fill the buffer while TX is stalled
    send_beat("t5_b1", 2'd0, 3'd4, 32'h03020100);
    send_beat("t5_b2", 2'd0, 3'd4, 32'h07060504);
    send_beat("t5_b3", 2'd0, 3'd4, 32'h0B0A0908);
    send_beat("t5_b4", 2'd0, 3'd4, 32'h0F0E0D0C);
    send_beat("t5_b5", 2'd0, 3'd4, 32'h13121110);
    chk("t5_full_ready", 32'(md_if.md_rx_ready), 32'd0);
    md_if.md_rx_valid  = 1'b1;
    md_if.md_rx_offset = 2'd0;
    md_if.md_rx_size   = 3'd4;
    md_if.md_rx_data   = 32'h17161514;
    cyc();
    cyc();
    cyc();
    chk("t5_stall_ready", 32'(md_if.md_rx_ready), 32'd0);
    chk("t5_stall_valid", 32'(md_if.md_tx_valid), 32'd1);
    chk("t5_stall_data",  md_if.md_tx_data, 32'h03020100);
    tx_accept();
    rdy = 1'b0;
    for (int n = 0; n < 10 && !rdy; n++) begin
      rdy = md_if.md_rx_ready;
      cyc();
    end
    md_if.md_rx_valid = 1'b0;
    chk("t5_b6_acc", 32'(rdy), 32'd1);
    wait_tx("t5_w2");
    chk("t5_word2", md_if.md_tx_data, 32'h07060504);
    tx_accept();
    wait_tx("t5_w3");
    chk("t5_word3", md_if.md_tx_data, 32'h0B0A0908);
    tx_accept();
    wait_tx("t5_w4");
    chk("t5_word4", md_if.md_tx_data, 32'h0F0E0D0C);
    tx_accept();
    wait_tx("t5_w5");
    chk("t5_word5", md_if.md_tx_data, 32'h13121110);
    tx_accept();
    wait_tx("t5_w6");
    chk("t5_word6", md_if.md_tx_data, 32'h17161514);
    tx_accept();
    cyc();
    cyc();
    chk("t5_empty", 32'(md_if.md_tx_valid), 32'd0);

    // Reset while holding a word with 8 bytes buffered
    send_beat("t6_b1", 2'd0, 3'd4, 32'hA3A2A1A0);
    send_beat("t6_b2", 2'd0, 3'd4, 32'hA7A6A5A4);
    send_beat("t6_b3", 2'd0, 3'd4, 32'hABAAA9A8);
    wait_tx("t6_hold");
    reset_n = 1'b0;
    cyc();
    chk("t6_rst_valid", 32'(md_if.md_tx_valid), 32'd0);
    chk("t6_rst_data",  md_if.md_tx_data, 32'd0);
    chk("t6_rst_off",   32'(md_if.md_tx_offset), 32'd0);
    chk("t6_rst_size",  32'(md_if.md_tx_size), 32'd0);
    chk("t6_rst_ready", 32'(md_if.md_rx_ready), 32'd0);
    reset_n = 1'b1;
    cyc();
    chk("t6_rel_ready", 32'(md_if.md_rx_ready), 32'd1);
    cyc();
    cyc();
    cyc();
    chk("t6_cnt_zero", 32'(md_if.md_tx_valid), 32'd0);
    send_beat("t6_acc", 2'd0, 3'd4, 32'h5A5B5C5D);
    wait_tx("t6_wait");
    chk("t6_word", md_if.md_tx_data, 32'h5A5B5C5D);
    tx_accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
